result_serializer: RTL and testbench
====================================

# result_serializer

Parallel-to-serial output stage that sits after `compressor`, the mirror of the input shift register that loads the operand rows. It captures the compressor's result bits in one cycle on a load strobe, then shifts them out LSB-first, one bit per accepted transfer, under a valid/ready handshake. It also computes a running parity over the transmitted bits. Lets a bench or pin-limited top read a wide result through one output pin.

## Interface
- `WIDTH`, default 30: number of result bits captured and shifted; must be ≥ 2.
- `clk`  in  1: single clock, all state updates on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `load`  in  1: capture request; sampled only when not busy.
- `din`  in  WIDTH: result word; bit i = `dst<i>` of the compressor.
- `dout`  out  1: current serial bit.
- `dout_valid`  out  1: `dout` is valid.
- `dout_ready`  in  1: consumer accepts `dout` this cycle.
- `dout_last`  out  1: current bit is bit WIDTH-1.
- `busy`  out  1: a word is being shifted.
- `done`  out  1: one-cycle pulse after the final bit is accepted.
- `parity`  out  1: XOR of all WIDTH transmitted bits; valid while `done`=1, holds until next load.
- `overrun`  out  1: sticky; set when `load`=1 while `busy`=1.

## Operation
- States: IDLE, SHIFT.
- IDLE: `dout_valid`=0, `busy`=0.
  - `load`=1 captures `din` into the shift register, clears the bit counter and running parity, and goes to SHIFT.
- SHIFT: `dout_valid`=1, `busy`=1, `dout`=shreg[0].
  - On `dout_valid && dout_ready`:
    - shreg shifts right by one, zero-filled;
    - running parity ^= `dout`;
    - counter increments.
  - If the transferred bit was the last one (counter == WIDTH-1), go to IDLE and assert `done` next cycle.
- `dout_last` = SHIFT && counter == WIDTH-1.
- `dout_ready`=0 stalls indefinitely. `dout`, `dout_last` and the counter hold while stalled.
- `load` while busy:
  - ignored;
  - the word in flight is unaffected;
  - `overrun` set, cleared only by `rst`.
- `load` in the cycle `done`=1 is legal: state is IDLE, so the new word is captured.
- Counter width: $clog2(WIDTH); no wrap occurs because the state leaves SHIFT at WIDTH-1.
- `rst` mid-transfer: the word is abandoned, no `done` is issued.

## Timing
- Reset values:
  - `dout`=0, `dout_valid`=0, `dout_last`=0;
  - `busy`=0, `done`=0, `parity`=0, `overrun`=0;
  - state IDLE, shreg=0, counter=0.
- `load` sampled at edge t gives `dout_valid`=1 with `dout`=din[0] from t+1.
- With `dout_ready` held at 1:
  - bit k is presented in cycle t+1+k;
  - last bit in cycle t+WIDTH;
  - `done`=1 and `busy`=0 in cycle t+WIDTH+1.
- Back-to-back throughput: one word per WIDTH+1 cycles (a load coincident with `done`).
- All outputs are registered or decoded from registered state only; there is no combinational path from `dout_ready` or `load` to any output.

## Structure
- Shared package `serializer_pkg`:
  - state enum (IDLE, SHIFT);
  - default result width constant (30, matching `compressor` dst count).
- One natural sub-module, `bit_counter`: a WIDTH-terminal counter with clear, enable, and terminal-count flag. The FSM, shift register and parity stay in the top.

## Test plan
- Reset then idle, `load`=0 for 5 cycles -> all outputs 0, `dout_valid` never asserted.
- WIDTH=30, `din`=30'h2AAAAAAA, `load` one cycle, `dout_ready`=1:
  - bits observed 0,1,0,1,...,1 over cycles 1..30;
  - `dout_last` in cycle 30;
  - `done` in cycle 31 with `parity`=1 (15 ones).
- `din`=30'h3FFFFFFF with `dout_ready` toggling 1,0,1,0 -> exactly 30 accepted ones, stalls hold `dout`, `parity`=0 at `done`.
- `load` asserted in cycle 10 of a transfer of `din`=30'h00000001 -> stream unchanged (1 then 29 zeros), `overrun`=1 and remains 1, `parity`=1.
- `load` with `din`=30'h1 in the `done` cycle of a previous word -> new word starts next cycle, no gap beyond the done cycle, second `parity`=1.
- `rst` asserted in cycle 12 of a transfer -> next cycle all outputs at reset values, no `done`. A subsequent `load` transfers a full 30-bit word correctly.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared types and constants for the result serializer slice.
package serializer_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int RESULT_W = 30;  // compressor dst bit count
endpackage

// File: rtl/result_serializer_bit_counter.sv
// Counts accepted bits of one word; term flags the final bit position.
module bit_counter #(
  parameter int WIDTH = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + CW'(1);
  end

  assign term = (cnt == CW'(WIDTH - 1));
endmodule

// File: rtl/result_serializer.sv
// Captures a result word on load, then streams it LSB-first over valid/ready with running parity.
module result_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH = RESULT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             busy,
  output logic             done,
  output logic             parity,
  output logic             overrun
);
  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             par;
  logic             cnt_term;
  logic             accept;

  assign accept = (state == SHIFT) && dout_ready;

  // Held at zero while idle so a load always starts from bit 0; stops at the last bit.
  bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .en   (accept && !cnt_term),
    .term (cnt_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      par     <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shreg <= din;
            par   <= 1'b0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (load) overrun <= 1'b1;
          if (dout_ready) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
            par   <= par ^ shreg[0];
            if (cnt_term) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dout_valid = (state == SHIFT);
  assign busy       = (state == SHIFT);
  assign dout       = dout_valid & shreg[0];
  assign dout_last  = dout_valid & cnt_term;
  assign parity     = par;
endmodule

// File: tb/tb_result_serializer.sv
// Transaction-level check of result_serializer: expected bits come straight from the loaded word.
module tb_result_serializer;
  localparam int W = 30;

  logic         clk = 1'b0;
  logic         rst, load, dout_ready;
  logic [W-1:0] din;
  logic         dout, dout_valid, dout_last, busy, done, parity, overrun;

  int checks = 0;
  int fails  = 0;
  logic exp_par = 1'b0;
  logic ovr_exp = 1'b0;

  always #5 clk = ~clk;

  result_serializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load(load), .din(din),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy), .done(done),
    .parity(parity), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_parity", parity, 0);
    chk("rst_overrun", overrun, 0);
    exp_par = 1'b0;
    ovr_exp = 1'b0;
  endtask

  task automatic idle(input int n);
    load = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("idle_valid", dout_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_parity", parity, exp_par);
      chk("idle_overrun", overrun, ovr_exp);
    end
  endtask

  // Called at a negedge with the DUT idle (or in its done cycle). mode: 0 ready=1, 1 toggle, 2 random.
  // Returns at the done negedge so a following call loads in the done cycle.
  task automatic xfer(input logic [W-1:0] w, input int mode, input int ovr_at, input int rst_at);
    int c = 0;
    int k = 0;
    logic rdy;
    load = 1'b1;
    din  = w;
    while (k < W) begin
      @(negedge clk);
      c++;
      if (c > 2000) begin
        chk("timeout", 1, 0);
        break;
      end
      chk("valid", dout_valid, 1);
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      chk("dout", dout, w[k]);
      chk("last", dout_last, (k == W - 1));
      chk("overrun", overrun, ovr_exp);
      if (c == rst_at) begin
        rst = 1'b1; load = 1'b0; dout_ready = 1'b0;
        @(negedge clk);
        chk_reset_state();
        rst = 1'b0;
        return;
      end
      load = (c == ovr_at);
      if (load) begin
        din = W'($urandom);
        ovr_exp = 1'b1;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = c[0];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      dout_ready = rdy;
      if (rdy) k++;
    end
    load = 1'b0;
    @(negedge clk);
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", dout_valid, 0);
    chk("done_last", dout_last, 0);
    chk("done_parity", parity, ^w);
    chk("done_overrun", overrun, ovr_exp);
    if (mode == 0) chk("latency", c, W);
    exp_par = ^w;
    dout_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; dout_ready = 1'b0; din = '0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_state();
    rst = 1'b0;
    idle(5);

    xfer(30'h2AAAAAAA, 0, -1, -1);
    idle(2);
    xfer(30'h3FFFFFFF, 1, -1, -1);
    idle(1);
    xfer(30'h00000001, 0, 10, -1);
    idle(2);
    // back-to-back: second load lands in the first word's done cycle
    xfer(W'($urandom), 0, -1, -1);
    xfer(30'h00000001, 0, -1, -1);
    idle(1);

    for (int i = 0; i < 25; i++) begin
      int m, ov;
      m  = $urandom_range(0, 2);
      ov = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, W - 1)) : -1;
      xfer(W'($urandom), m, ov, -1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(1);

    // abandon a word mid-flight, then a clean full transfer
    xfer(W'($urandom), 0, -1, 12);
    idle(3);
    xfer(W'($urandom), 2, -1, -1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
